// File: rtl/reg_bank_defs_pkg.sv
// Shared definitions for the parametrised register bank: default sizing and
// the clear-engine state encoding used by the FSM sub-module.
package reg_bank_defs;

   localparam int DEFAULT_WIDTH  = 64;
   localparam int DEFAULT_ADDR_W = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } clearState_t;

endpackage

// File: rtl/reg_bank_clear_fsm.sv
// Clear engine for the register bank. After reset, or on a Clear request
// while idle, it walks every entry from 0 to DEPTH-1 and produces one zeroing
// strobe per cycle. Busy is high for the whole walk.
module reg_bank_clear_fsm
   import reg_bank_defs::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Clear,
   output logic              Busy,
   output logic              ClearStrobe,
   output logic [ADDR_W-1:0] ClearAddr
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

   clearState_t       state;
   clearState_t       nextState;
   logic [ADDR_W-1:0] counter;
   logic [ADDR_W-1:0] nextCounter;

   // State and counter registers; reset always restarts the walk at entry 0
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state   <= ST_CLEAR;
         counter <= '0;
      end else begin
         state   <= nextState;
         counter <= nextCounter;
      end
   end

   // Next-state logic: CLEAR steps through all entries, IDLE waits for Clear
   always_comb begin
      nextState   = state;
      nextCounter = counter;
      case (state)
         ST_CLEAR: begin
            nextCounter = counter + 1'b1;
            if (counter == LAST_ADDR) begin
               nextState = ST_IDLE;
            end
         end
         ST_IDLE: begin
            if (Clear) begin
               nextState   = ST_CLEAR;
               nextCounter = '0;
            end
         end
         default: begin
            nextState   = ST_CLEAR;
            nextCounter = '0;
         end
      endcase
   end

   assign Busy        = (state == ST_CLEAR);
   assign ClearStrobe = (state == ST_CLEAR);
   assign ClearAddr   = counter;

endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank feeding the ALU operand inputs: two registered
// read ports, one write port, optional hardwired zero entry, optional
// write-to-read bypass and a sequential clear engine.
module reg_bank_param
   import reg_bank_defs::*;
#(
   parameter int WIDTH    = DEFAULT_WIDTH,
   parameter int ADDR_W   = DEFAULT_ADDR_W,
   parameter bit ZERO_REG = 1'b1,
   parameter bit BYPASS   = 1'b1
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Clear,
   input  logic              ReadEn,
   input  logic [ADDR_W-1:0] ReadRegister1,
   input  logic [ADDR_W-1:0] ReadRegister2,
   input  logic              RegWrite,
   input  logic [ADDR_W-1:0] WriteRegister,
   input  logic [WIDTH-1:0]  WriteData,
   output logic [WIDTH-1:0]  ReadData1,
   output logic [WIDTH-1:0]  ReadData2,
   output logic              ReadValid,
   output logic              Busy
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [WIDTH-1:0]  regFile [DEPTH];
   logic              busy;
   logic              clearStrobe;
   logic [ADDR_W-1:0] clearAddr;
   logic              writeAccept;
   logic              readAccept;
   logic [WIDTH-1:0]  readNext1;
   logic [WIDTH-1:0]  readNext2;

   reg_bank_clear_fsm #(
      .ADDR_W (ADDR_W)
   ) uClearFsm (
      .Clk         (Clk),
      .Rst_n       (Rst_n),
      .Clear       (Clear),
      .Busy        (busy),
      .ClearStrobe (clearStrobe),
      .ClearAddr   (clearAddr)
   );

   // A user write lands only when idle, not pre-empted by Clear, and not aimed at the zero entry
   always_comb begin
      writeAccept = !busy && RegWrite && !Clear && !(ZERO_REG && (WriteRegister == '0));
      readAccept  = !busy && ReadEn;
   end

   // Read data selection: stored value, optionally bypassed write data, zero entry forced last
   always_comb begin
      readNext1 = regFile[ReadRegister1];
      readNext2 = regFile[ReadRegister2];
      if (BYPASS && writeAccept && (ReadRegister1 == WriteRegister)) begin
         readNext1 = WriteData;
      end
      if (BYPASS && writeAccept && (ReadRegister2 == WriteRegister)) begin
         readNext2 = WriteData;
      end
      if (ZERO_REG && (ReadRegister1 == '0)) begin
         readNext1 = '0;
      end
      if (ZERO_REG && (ReadRegister2 == '0)) begin
         readNext2 = '0;
      end
   end

   // Storage array has no reset; the clear engine zeroes it, otherwise user writes land
   always_ff @(posedge Clk) begin
      if (clearStrobe) begin
         regFile[clearAddr] <= '0;
      end else if (writeAccept) begin
         regFile[WriteRegister] <= WriteData;
      end
   end

   // Registered read ports; data holds when no read is accepted, valid flags a fresh read
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         ReadData1 <= '0;
         ReadData2 <= '0;
         ReadValid <= 1'b0;
      end else begin
         ReadValid <= readAccept;
         if (readAccept) begin
            ReadData1 <= readNext1;
            ReadData2 <= readNext2;
         end
      end
   end

   assign Busy = busy;

endmodule

// File: tb/tb_reg_bank_param.sv
// Bench for reg_bank_param: one bypassing and one non-bypassing instance share
// the same stimulus. A transaction-level model predicts both every cycle, and
// directed steps pin key results with literal values.
module tb_reg_bank_param;

   localparam int WIDTH  = 64;
   localparam int ADDR_W = 5;
   localparam int DEPTH  = 32;

   logic              Clk = 1'b0;
   logic              Rst_n = 1'b1;
   logic              Clear = 1'b0;
   logic              ReadEn = 1'b0;
   logic [ADDR_W-1:0] rr1 = '0;
   logic [ADDR_W-1:0] rr2 = '0;
   logic              RegWrite = 1'b0;
   logic [ADDR_W-1:0] wr = '0;
   logic [WIDTH-1:0]  wd = '0;

   logic [WIDTH-1:0]  rdB1, rdB2, rdN1, rdN2;
   logic              validB, validN, busyB, busyN;

   int checks   = 0;
   int failures = 0;

   reg_bank_param #(
      .WIDTH (WIDTH), .ADDR_W (ADDR_W), .ZERO_REG (1'b1), .BYPASS (1'b1)
   ) dutBypass (
      .Clk (Clk), .Rst_n (Rst_n), .Clear (Clear), .ReadEn (ReadEn),
      .ReadRegister1 (rr1), .ReadRegister2 (rr2), .RegWrite (RegWrite),
      .WriteRegister (wr), .WriteData (wd), .ReadData1 (rdB1),
      .ReadData2 (rdB2), .ReadValid (validB), .Busy (busyB)
   );

   reg_bank_param #(
      .WIDTH (WIDTH), .ADDR_W (ADDR_W), .ZERO_REG (1'b1), .BYPASS (1'b0)
   ) dutNoBypass (
      .Clk (Clk), .Rst_n (Rst_n), .Clear (Clear), .ReadEn (ReadEn),
      .ReadRegister1 (rr1), .ReadRegister2 (rr2), .RegWrite (RegWrite),
      .WriteRegister (wr), .WriteData (wd), .ReadData1 (rdN1),
      .ReadData2 (rdN2), .ReadValid (validN), .Busy (busyN)
   );

   // Free-running clock
   always #5 Clk = ~Clk;

   task automatic checkOutput(input string name, input logic [WIDTH-1:0] actual,
                              input logic [WIDTH-1:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
      end
   endtask

   // Model state: entry contents, cycles of clearing still to run, expected outputs
   logic [WIDTH-1:0] modelMem [DEPTH];
   int               busyLeft = DEPTH;
   logic [WIDTH-1:0] expRd1 [2];
   logic [WIDTH-1:0] expRd2 [2];
   logic             expValid = 1'b0;

   // What a read of addr returns this cycle; variant 0 bypasses, variant 1 does not
   function automatic logic [WIDTH-1:0] modelRead(input int variant, input logic [ADDR_W-1:0] addr);
      if (addr == 0) return '0;
      if (variant == 0 && RegWrite && !Clear && wr == addr) return wd;
      return modelMem[addr];
   endfunction

   // Behavioural model advanced on each clock edge and on asynchronous reset
   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         busyLeft <= DEPTH;
         expValid <= 1'b0;
         for (int v = 0; v < 2; v++) begin
            expRd1[v] <= '0;
            expRd2[v] <= '0;
         end
         for (int i = 0; i < DEPTH; i++) modelMem[i] <= '0;
      end else if (busyLeft > 0) begin
         busyLeft <= busyLeft - 1;
         expValid <= 1'b0;
      end else begin
         expValid <= ReadEn;
         if (ReadEn) begin
            for (int v = 0; v < 2; v++) begin
               expRd1[v] <= modelRead(v, rr1);
               expRd2[v] <= modelRead(v, rr2);
            end
         end
         if (Clear) begin
            busyLeft <= DEPTH;
            for (int i = 0; i < DEPTH; i++) modelMem[i] <= '0;
         end else if (RegWrite && wr != 0) begin
            modelMem[wr] <= wd;
         end
      end
   end

   // Cycle-by-cycle comparison of both instances against the model
   always @(negedge Clk) begin
      checkOutput("busyB",  64'(busyB),  64'(busyLeft > 0));
      checkOutput("busyN",  64'(busyN),  64'(busyLeft > 0));
      checkOutput("validB", 64'(validB), 64'(expValid));
      checkOutput("validN", 64'(validN), 64'(expValid));
      checkOutput("rdB1", rdB1, expRd1[0]);
      checkOutput("rdB2", rdB2, expRd2[0]);
      checkOutput("rdN1", rdN1, expRd1[1]);
      checkOutput("rdN2", rdN2, expRd2[1]);
   end

   // Drive one cycle of inputs, starting and ending two time units after a rising edge
   task automatic applyStimulus(input logic clr, input logic re,
                                input logic [ADDR_W-1:0] a1, input logic [ADDR_W-1:0] a2,
                                input logic we, input logic [ADDR_W-1:0] wa,
                                input logic [WIDTH-1:0] data);
      Clear    = clr;
      ReadEn   = re;
      rr1      = a1;
      rr2      = a2;
      RegWrite = we;
      wr       = wa;
      wd       = data;
      @(posedge Clk);
      #2;
      Clear    = 1'b0;
      ReadEn   = 1'b0;
      RegWrite = 1'b0;
   endtask

   // Count rising edges while Busy stays high, bounded
   task automatic countBusy(output int n);
      n = 0;
      while (busyB && n < 100) begin
         @(posedge Clk);
         #2;
         n++;
      end
   endtask

   int n;

   initial begin
      // Reset and initial clear walk
      #1 Rst_n = 1'b0;
      @(posedge Clk);
      @(posedge Clk);
      #2 Rst_n = 1'b1;
      checkOutput("busyAtRelease", 64'(busyB), 64'd1);
      countBusy(n);
      checkOutput("busyLenReset", 64'(n), 64'd32);

      // Every entry reads zero after the walk
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, 1'b1, 5'(a), 5'(DEPTH - 1 - a), 1'b0, '0, '0);
         checkOutput("t1Rd", rdB1, 64'h0);
         checkOutput("t1Valid", 64'(validB), 64'd1);
      end

      // Write then read on both ports
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd7, 64'hDEADBEEF_CAFEF00D);
      applyStimulus(1'b0, 1'b1, 5'd7, 5'd7, 1'b0, '0, '0);
      checkOutput("t2RdB1", rdB1, 64'hDEADBEEF_CAFEF00D);
      checkOutput("t2RdB2", rdB2, 64'hDEADBEEF_CAFEF00D);
      checkOutput("t2RdN2", rdN2, 64'hDEADBEEF_CAFEF00D);
      checkOutput("t2Valid", 64'(validN), 64'd1);

      // Same-cycle hazard on entry 3
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd3, 64'h11);
      applyStimulus(1'b0, 1'b1, 5'd3, 5'd7, 1'b1, 5'd3, 64'h22);
      checkOutput("t3Bypass", rdB1, 64'h22);
      checkOutput("t3NoBypass", rdN1, 64'h11);
      applyStimulus(1'b0, 1'b1, 5'd3, 5'd3, 1'b0, '0, '0);
      checkOutput("t3AfterB", rdB1, 64'h22);
      checkOutput("t3AfterN", rdN2, 64'h22);

      // Zero entry ignores writes, including a same-cycle bypass attempt
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd0, 64'hFFFF);
      applyStimulus(1'b0, 1'b1, 5'd0, 5'd7, 1'b0, '0, '0);
      checkOutput("t4Zero", rdB1, 64'h0);
      applyStimulus(1'b0, 1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 64'hFFFF);
      checkOutput("t4ZeroBypB", rdB2, 64'h0);
      checkOutput("t4ZeroBypN", rdN1, 64'h0);

      // Fill, then Clear alongside a write, with traffic ignored while busy
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'(a), 64'h01234567_00000000 + 64'(a) + 64'd1);
      end
      applyStimulus(1'b0, 1'b1, 5'd5, 5'd31, 1'b0, '0, '0);
      checkOutput("t5Fill5", rdB1, 64'h01234567_00000006);
      checkOutput("t5Fill31", rdN2, 64'h01234567_00000020);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b1, 5'd5, 64'hBAD);
      n = 0;
      while (busyB && n < 100) begin
         applyStimulus(1'(n % 2), 1'b1, 5'(n), 5'(n), 1'b1, 5'(n), 64'hF00 + 64'(n));
         n++;
      end
      checkOutput("busyLenClear", 64'(n), 64'd32);
      for (int a = 0; a < DEPTH; a++) begin
         applyStimulus(1'b0, 1'b1, 5'(a), 5'(a), 1'b0, '0, '0);
      end
      applyStimulus(1'b0, 1'b1, 5'd5, 5'd12, 1'b0, '0, '0);
      checkOutput("t5Cleared5", rdB1, 64'h0);
      checkOutput("t5Cleared12", rdN2, 64'h0);

      // Reset part-way through a clear walk
      applyStimulus(1'b0, 1'b0, '0, '0, 1'b1, 5'd9, 64'h99);
      applyStimulus(1'b0, 1'b1, 5'd9, 5'd9, 1'b0, '0, '0);
      checkOutput("t6Before", rdB1, 64'h99);
      applyStimulus(1'b1, 1'b0, '0, '0, 1'b0, '0, '0);
      for (int c = 0; c < 10; c++) begin
         applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      end
      Rst_n = 1'b0;
      #1;
      checkOutput("t6RdZero", rdB1, 64'h0);
      checkOutput("t6ValidZero", 64'(validN), 64'd0);
      checkOutput("t6Busy", 64'(busyB), 64'd1);
      @(posedge Clk);
      @(posedge Clk);
      #2 Rst_n = 1'b1;
      countBusy(n);
      checkOutput("busyLenRestart", 64'(n), 64'd32);
      applyStimulus(1'b0, 1'b1, 5'd9, 5'd7, 1'b0, '0, '0);
      checkOutput("t6After", rdB1, 64'h0);

      applyStimulus(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
